// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters with a pixel-rate divider,
// producing a fully registered per-pixel VGA_Timing strobe plus raster position.
package vga_timing_pkg;
    typedef struct packed {
        logic valid;
        logic blank_n;
        logic hsync_n;
        logic vsync_n;
        logic end_of_line;
        logic end_of_frame;
    } VGA_Timing;
endpackage

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output VGA_Timing   timing_o,
    output logic [10:0] h_cnt_o,
    output logic [9:0]  v_cnt_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] D_LAST  = DW'(CLK_DIV - 1);
    localparam logic [10:0]   H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0]   H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0]   H_SS    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]   H_SE    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]    V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0]    V_SS    = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    V_SE    = 10'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL < 1 || H_TOTAL > 2048) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL must be in 1..2048");
    end
    if (V_TOTAL < 1 || V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL must be in 1..1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be in 1..16");
    end

    logic [DW-1:0] d;
    logic [10:0]   h;
    logic [9:0]    v;
    logic          tick;
    logic          h_wrap;
    logic          v_wrap;

    assign tick   = en_i && (d == D_LAST);
    assign h_wrap = (h == H_LAST);
    assign v_wrap = (v == V_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d        <= '0;
            h        <= '0;
            v        <= '0;
            timing_o <= '{valid: 1'b0, blank_n: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
                          end_of_line: 1'b0, end_of_frame: 1'b0};
            h_cnt_o  <= '0;
            v_cnt_o  <= '0;
        end else begin
            // Dropping enable restarts the divider so resume waits a full pixel period
            if (!en_i || tick) d <= '0;
            else               d <= d + 1'b1;

            timing_o.valid        <= tick;
            timing_o.end_of_line  <= tick && h_wrap;
            timing_o.end_of_frame <= tick && h_wrap && v_wrap;

            if (tick) begin
                timing_o.blank_n <= (h < H_ACT) && (v < V_ACT);
                timing_o.hsync_n <= !((h >= H_SS) && (h < H_SE));
                timing_o.vsync_n <= !((v >= V_SS) && (v < V_SE));
                h_cnt_o          <= h;
                v_cnt_o          <= v;
                if (h_wrap) begin
                    h <= '0;
                    v <= v_wrap ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small rasters at CLK_DIV 1 and 3 plus the default
// 640x480 raster, checked against an arithmetic pixel-index model.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int SHA = 4, SHF = 1, SHS = 2, SHB = 1;
    localparam int SVA = 3, SVF = 1, SVS = 1, SVB = 1;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;
    localparam int DEF_LINES = 30;

    localparam VGA_Timing RST_T = '{valid: 1'b0, blank_n: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
                                   end_of_line: 1'b0, end_of_frame: 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, rst_b, en_b, rst_c, en_c;
    VGA_Timing   t_a, t_b, t_c;
    logic [10:0] h_a, h_b, h_c;
    logic [9:0]  v_a, v_b, v_c;

    vga_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                     .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .CLK_DIV(1))
    u_a (.clk_i(clk), .rst_ni(rst_a), .en_i(en_a), .timing_o(t_a), .h_cnt_o(h_a), .v_cnt_o(v_a));

    vga_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                     .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .CLK_DIV(3))
    u_b (.clk_i(clk), .rst_ni(rst_b), .en_i(en_b), .timing_o(t_b), .h_cnt_o(h_b), .v_cnt_o(v_b));

    vga_timing_gen u_c (.clk_i(clk), .rst_ni(rst_c), .en_i(en_c), .timing_o(t_c),
                        .h_cnt_o(h_c), .v_cnt_o(v_c));

    int checks   = 0;
    int failures = 0;

    // Reference model: pixel index p counts emitted pixels since reset; a pixel is
    // emitted after div consecutive enabled edges; position is plain p mod/div arithmetic.
    VGA_Timing m_t[2];
    int        m_h[2], m_v[2], m_run[2], m_p[2];

    function automatic VGA_Timing pix(int h, int v, int ha, int hf, int hs, int hb,
                                      int va, int vf, int vs, int vb);
        VGA_Timing t;
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        t.valid        = 1'b1;
        t.blank_n      = (h < ha) && (v < va);
        t.hsync_n      = !(h >= ha + hf && h < ha + hf + hs);
        t.vsync_n      = !(v >= va + vf && v < va + vf + vs);
        t.end_of_line  = (h == ht - 1);
        t.end_of_frame = (h == ht - 1) && (v == vt - 1);
        return t;
    endfunction

    task automatic model_reset(input int i);
        m_t[i] = RST_T; m_h[i] = 0; m_v[i] = 0; m_run[i] = 0; m_p[i] = 0;
    endtask

    task automatic model_step(input int i, input bit en, input int div);
        m_t[i].valid = 1'b0; m_t[i].end_of_line = 1'b0; m_t[i].end_of_frame = 1'b0;
        if (!en) begin
            m_run[i] = 0;
        end else begin
            m_run[i]++;
            if (m_run[i] == div) begin
                m_run[i] = 0;
                m_h[i] = m_p[i] % SHT;
                m_v[i] = (m_p[i] / SHT) % SVT;
                m_p[i]++;
                m_t[i] = pix(m_h[i], m_v[i], SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
            end
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        #2;
        repeat (2) tick_clk();
        model_reset(0); model_reset(1);
        checks++;
        if ({t_a, h_a, v_a} !== {RST_T, 11'd0, 10'd0}) begin
            failures++;
            $display("FAIL reset_a: got t=%b h=%0d v=%0d, want t=%b h=0 v=0", t_a, h_a, v_a, RST_T);
        end
        checks++;
        if ({t_b, h_b, v_b} !== {RST_T, 11'd0, 10'd0}) begin
            failures++;
            $display("FAIL reset_b: got t=%b h=%0d v=%0d, want t=%b h=0 v=0", t_b, h_b, v_b, RST_T);
        end
        checks++;
        if ({t_c, h_c, v_c} !== {RST_T, 11'd0, 10'd0}) begin
            failures++;
            $display("FAIL reset_c: got t=%b h=%0d v=%0d, want t=%b h=0 v=0", t_c, h_c, v_c, RST_T);
        end
    endtask

    task automatic test_frame_div1();
        int n_val = 0, n_eol = 0, n_eof = 0, n_blank = 0, n_hs = 0, n_vs = 0;
        int eof_k = -1, eof_v = -1;
        rst_a = 1'b1; en_a = 1'b1;
        for (int k = 1; k <= 49; k++) begin
            model_step(0, 1'b1, 1);
            tick_clk();
            checks++;
            if ({t_a, h_a, v_a} !== {m_t[0], 11'(m_h[0]), 10'(m_v[0])}) begin
                failures++;
                $display("FAIL frame_div1 cyc %0d: got t=%b h=%0d v=%0d, want t=%b h=%0d v=%0d",
                         k, t_a, h_a, v_a, m_t[0], m_h[0], m_v[0]);
            end
            if (k <= 48) begin
                n_val   += int'(t_a.valid);
                n_eol   += int'(t_a.end_of_line);
                n_blank += int'(t_a.blank_n);
                n_hs    += int'(!t_a.hsync_n);
                n_vs    += int'(!t_a.vsync_n);
                if (t_a.end_of_frame) begin n_eof++; eof_k = k; eof_v = int'(v_a); end
            end
        end
        checks++;
        if (n_val !== 48 || n_eol !== 6 || n_eof !== 1) begin
            failures++;
            $display("FAIL frame_div1_counts: got valid=%0d eol=%0d eof=%0d, want 48 6 1", n_val, n_eol, n_eof);
        end
        checks++;
        if (eof_k !== 48 || eof_v !== 5) begin
            failures++;
            $display("FAIL frame_div1_eof_pos: got cyc=%0d v=%0d, want cyc=48 v=5", eof_k, eof_v);
        end
        checks++;
        if (n_blank !== 12 || n_hs !== 12 || n_vs !== 8) begin
            failures++;
            $display("FAIL frame_div1_levels: got blank=%0d hs_low=%0d vs_low=%0d, want 12 12 8",
                     n_blank, n_hs, n_vs);
        end
        checks++;
        if (h_a !== 11'd0 || v_a !== 10'd0 || t_a.valid !== 1'b1) begin
            failures++;
            $display("FAIL frame_div1_wrap: got h=%0d v=%0d valid=%b, want h=0 v=0 valid=1", h_a, v_a, t_a.valid);
        end
    endtask

    task automatic test_clkdiv3();
        int n_val = 0;
        rst_b = 1'b1; en_b = 1'b1;
        for (int k = 1; k <= 147; k++) begin
            model_step(1, 1'b1, 3);
            tick_clk();
            checks++;
            if ({t_b, h_b, v_b} !== {m_t[1], 11'(m_h[1]), 10'(m_v[1])}) begin
                failures++;
                $display("FAIL clkdiv3 cyc %0d: got t=%b h=%0d v=%0d, want t=%b h=%0d v=%0d",
                         k, t_b, h_b, v_b, m_t[1], m_h[1], m_v[1]);
            end
            checks++;
            if (t_b.valid !== (k % 3 == 0)) begin
                failures++;
                $display("FAIL clkdiv3_cadence cyc %0d: got valid=%b, want %b", k, t_b.valid, (k % 3 == 0));
            end
            n_val += int'(t_b.valid);
        end
        checks++;
        if (n_val !== 49) begin
            failures++;
            $display("FAIL clkdiv3_count: got valid=%0d, want 49", n_val);
        end
    endtask

    task automatic test_en_gap();
        int n_eof = 0;
        rst_a = 1'b0;
        tick_clk();
        model_reset(0);
        rst_a = 1'b1; en_a = 1'b1;
        for (int k = 0; k < 11; k++) begin
            model_step(0, 1'b1, 1); tick_clk();
            n_eof += int'(t_a.end_of_frame);
        end
        checks++;
        if (h_a !== 11'd2 || v_a !== 10'd1 || t_a.valid !== 1'b1) begin
            failures++;
            $display("FAIL en_gap_pre: got h=%0d v=%0d valid=%b, want h=2 v=1 valid=1", h_a, v_a, t_a.valid);
        end
        en_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            model_step(0, 1'b0, 1); tick_clk();
            n_eof += int'(t_a.end_of_frame);
            checks++;
            if ({t_a, h_a, v_a} !== {m_t[0], 11'(m_h[0]), 10'(m_v[0])} || t_a.valid !== 1'b0) begin
                failures++;
                $display("FAIL en_gap_hold cyc %0d: got t=%b h=%0d v=%0d, want t=%b h=%0d v=%0d",
                         k, t_a, h_a, v_a, m_t[0], m_h[0], m_v[0]);
            end
        end
        en_a = 1'b1;
        model_step(0, 1'b1, 1); tick_clk();
        checks++;
        if (h_a !== 11'd3 || v_a !== 10'd1 || t_a.valid !== 1'b1) begin
            failures++;
            $display("FAIL en_gap_resume: got h=%0d v=%0d valid=%b, want h=3 v=1 valid=1", h_a, v_a, t_a.valid);
        end
        for (int k = 0; k < 36; k++) begin
            model_step(0, 1'b1, 1); tick_clk();
            n_eof += int'(t_a.end_of_frame);
        end
        checks++;
        if (n_eof !== 1 || h_a !== 11'd7 || v_a !== 10'd5) begin
            failures++;
            $display("FAIL en_gap_frame: got eof=%0d last h=%0d v=%0d, want eof=1 h=7 v=5", n_eof, h_a, v_a);
        end
    endtask

    task automatic test_async_reset();
        rst_a = 1'b0;
        tick_clk();
        model_reset(0);
        rst_a = 1'b1; en_a = 1'b1;
        for (int k = 0; k < 39; k++) begin
            model_step(0, 1'b1, 1); tick_clk();
        end
        checks++;
        if (h_a !== 11'd6 || v_a !== 10'd4) begin
            failures++;
            $display("FAIL async_pre: got h=%0d v=%0d, want h=6 v=4", h_a, v_a);
        end
        #3 rst_a = 1'b0;
        #1;
        model_reset(0);
        checks++;
        if ({t_a, h_a, v_a} !== {RST_T, 11'd0, 10'd0}) begin
            failures++;
            $display("FAIL async_now: got t=%b h=%0d v=%0d, want t=%b h=0 v=0", t_a, h_a, v_a, RST_T);
        end
        tick_clk();
        rst_a = 1'b1;
        model_step(0, 1'b1, 1); tick_clk();
        checks++;
        if ({t_a, h_a, v_a} !== {m_t[0], 11'd0, 10'd0} || t_a.blank_n !== 1'b1) begin
            failures++;
            $display("FAIL async_restart: got t=%b h=%0d v=%0d, want t=%b h=0 v=0", t_a, h_a, v_a, m_t[0]);
        end
    endtask

    task automatic test_random_en();
        bit ea, eb;
        rst_a = 1'b0; rst_b = 1'b0;
        tick_clk();
        model_reset(0); model_reset(1);
        rst_a = 1'b1; rst_b = 1'b1;
        for (int k = 0; k < 300; k++) begin
            ea = ($urandom_range(0, 3) != 0);
            eb = ($urandom_range(0, 4) != 0);
            en_a = ea; en_b = eb;
            model_step(0, ea, 1);
            model_step(1, eb, 3);
            tick_clk();
            checks++;
            if ({t_a, h_a, v_a} !== {m_t[0], 11'(m_h[0]), 10'(m_v[0])}) begin
                failures++;
                $display("FAIL random_a cyc %0d: got t=%b h=%0d v=%0d, want t=%b h=%0d v=%0d",
                         k, t_a, h_a, v_a, m_t[0], m_h[0], m_v[0]);
            end
            checks++;
            if ({t_b, h_b, v_b} !== {m_t[1], 11'(m_h[1]), 10'(m_v[1])}) begin
                failures++;
                $display("FAIL random_b cyc %0d: got t=%b h=%0d v=%0d, want t=%b h=%0d v=%0d",
                         k, t_b, h_b, v_b, m_t[1], m_h[1], m_v[1]);
            end
        end
    endtask

    task automatic test_default();
        int bad = 0, first_bad = -1, n_val = 0, n_eol = 0, n_blank = 0, n_hs = 0;
        VGA_Timing e;
        int p, hh, vv;
        rst_c = 1'b1; en_c = 1'b1;
        for (int k = 1; k <= DEF_LINES * 800; k++) begin
            tick_clk();
            p  = k - 1;
            hh = p % 800;
            vv = (p / 800) % 525;
            e  = pix(hh, vv, 640, 16, 96, 48, 480, 10, 2, 33);
            if ({t_c, h_c, v_c} !== {e, 11'(hh), 10'(vv)}) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            n_val   += int'(t_c.valid);
            n_eol   += int'(t_c.end_of_line);
            n_blank += int'(t_c.blank_n);
            n_hs    += int'(!t_c.hsync_n);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL default_raster: got %0d bad cycles (first %0d), want 0", bad, first_bad);
        end
        checks++;
        if (n_val !== DEF_LINES * 800 || n_eol !== DEF_LINES) begin
            failures++;
            $display("FAIL default_counts: got valid=%0d eol=%0d, want %0d %0d",
                     n_val, n_eol, DEF_LINES * 800, DEF_LINES);
        end
        checks++;
        if (n_blank !== DEF_LINES * 640 || n_hs !== DEF_LINES * 96) begin
            failures++;
            $display("FAIL default_levels: got blank=%0d hs_low=%0d, want %0d %0d",
                     n_blank, n_hs, DEF_LINES * 640, DEF_LINES * 96);
        end
    endtask

    initial begin
        test_reset();
        test_frame_div1();
        test_clkdiv3();
        test_en_gap();
        test_async_reset();
        test_random_en();
        test_default();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
